// File: rtl/priority_decoder_pulser_if.sv
// Purpose: input handshake bundle carrying an 8:3-encoder result (index code plus "any active" flag).
// Latency: none; this file holds wires only.
// Backpressure: the consumer drives in_ready and the producer holds its code until in_valid && in_ready.
interface priority_decoder_pulser_if #(
  parameter int IDX_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [IDX_W-1:0] in_code;
  logic             in_f;

  // Producer side: drives the code, observes ready.
  modport master (
    output in_valid,
    output in_code,
    output in_f,
    input  in_ready
  );

  // Consumer side: samples the code, drives ready.
  modport slave (
    input  in_valid,
    input  in_code,
    input  in_f,
    output in_ready
  );
endinterface

// File: rtl/priority_decoder_pulser.sv
// Purpose: decode an encoder index back to a one-hot line held for PULSE_LEN cycles, then GAP_LEN zero cycles.
// Latency: onehot rises on the accept edge and stays high PULSE_LEN cycles; accepts are PULSE_LEN+GAP_LEN+1 apart.
// Backpressure: in_ready is high only in IDLE; null codes (in_f=0) are absorbed every cycle without leaving IDLE.
module priority_decoder_pulser #(
  parameter int IDX_W     = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  localparam int N        = 2**IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_decoder_pulser_if.slave bus,
  output logic [N-1:0]          onehot,
  output logic                  busy,
  output logic                  pulse_done,
  output logic [7:0]            null_cnt
);

  // Parameter sanity: an 8-bit counter cannot represent anything outside these ranges.
  generate
    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
      $fatal(1, "priority_decoder_pulser: PULSE_LEN=%0d is outside 1..255", PULSE_LEN);
    end
    if (GAP_LEN < 0 || GAP_LEN > 255) begin : g_bad_gap_len
      $fatal(1, "priority_decoder_pulser: GAP_LEN=%0d is outside 0..255", GAP_LEN);
    end
    if (IDX_W < 1) begin : g_bad_idx_w
      $fatal(1, "priority_decoder_pulser: IDX_W=%0d must be at least 1", IDX_W);
    end
  endgenerate

  // Counter reload values; the counter counts down to zero, so the load is length minus one.
  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP_LEN > 0) ? 8'(GAP_LEN - 1) : 8'd0;
  localparam logic [N-1:0] ONE      = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t         state;
  logic [7:0]     cnt;
  logic [N-1:0]   decoded;
  logic           accept;

  // Ready depends on state alone so there is no path from in_valid to in_ready.
  assign bus.in_ready = (state == IDLE);
  assign busy         = (state != IDLE);
  assign accept       = bus.in_valid && (state == IDLE);
  assign decoded      = ONE << bus.in_code;

  // Sequencer: IDLE waits for a code, PULSE holds the strobe, GAP forces the quiet interval.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      onehot     <= '0;
      pulse_done <= 1'b0;
      null_cnt   <= 8'd0;
    end else begin
      // pulse_done is a single-cycle marker; it is only re-asserted at the end of a pulse.
      pulse_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.in_f) begin
              onehot <= decoded;
              cnt    <= PULSE_LOAD;
              state  <= PULSE;
            end else if (null_cnt != 8'hFF) begin
              // No input was active at the encoder: count it, but never wrap.
              null_cnt <= null_cnt + 8'd1;
            end
          end
        end
        PULSE: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            onehot     <= '0;
            pulse_done <= 1'b1;
            if (GAP_LEN > 0) begin
              cnt   <= GAP_LOAD;
              state <= GAP;
            end else begin
              state <= IDLE;
            end
          end
        end
        GAP: begin
          onehot <= '0;
          if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          // Unreachable encoding: recover to a quiet IDLE.
          onehot <= '0;
          cnt    <= 8'd0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // The strobe never has more than one line active.
  a_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0(onehot));

  // A nonzero strobe only exists while a pulse is in progress.
  a_only_in_pulse: assert property (@(posedge clk) disable iff (rst)
    (onehot != '0) |-> (state == PULSE));

endmodule

// File: tb/tb_priority_decoder_pulser.sv
// Purpose: self-checking bench for priority_decoder_pulser with a default build and a PULSE_LEN=1/GAP_LEN=0 build.
// Latency: outputs are sampled on the falling edge, half a cycle after each rising edge.
// Backpressure: stimulus holds in_valid until the DUT shows in_ready.
module tb_priority_decoder_pulser;

  localparam int PA = 4;
  localparam int GA = 1;
  localparam int PB = 1;
  localparam int GB = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  priority_decoder_pulser_if #(.IDX_W(3)) a_if ();
  priority_decoder_pulser_if #(.IDX_W(3)) b_if ();

  logic [7:0] a_onehot, b_onehot;
  logic       a_busy, b_busy;
  logic       a_pd, b_pd;
  logic [7:0] a_null, b_null;

  priority_decoder_pulser #(.IDX_W(3), .PULSE_LEN(PA), .GAP_LEN(GA)) dut_a (
    .clk        (clk),
    .rst        (rst),
    .bus        (a_if),
    .onehot     (a_onehot),
    .busy       (a_busy),
    .pulse_done (a_pd),
    .null_cnt   (a_null)
  );

  priority_decoder_pulser #(.IDX_W(3), .PULSE_LEN(PB), .GAP_LEN(GB)) dut_b (
    .clk        (clk),
    .rst        (rst),
    .bus        (b_if),
    .onehot     (b_onehot),
    .busy       (b_busy),
    .pulse_done (b_pd),
    .null_cnt   (b_null)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  // Reference model: time-stamp arithmetic. mt = index of the last clock edge,
  // macc = edge on which the last valid code was taken, everything else follows
  // from the pulse/gap lengths.
  int         mt[2];
  int         macc[2];
  logic [2:0] mcode[2];
  int         mnull[2];

  logic       vin[2];
  logic [2:0] cin[2];
  logic       fin[2];
  assign vin[0] = a_if.in_valid;
  assign vin[1] = b_if.in_valid;
  assign cin[0] = a_if.in_code;
  assign cin[1] = b_if.in_code;
  assign fin[0] = a_if.in_f;
  assign fin[1] = b_if.in_f;

  function automatic int plen(int d);
    return (d == 0) ? PA : PB;
  endfunction

  function automatic int glen(int d);
    return (d == 0) ? GA : GB;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mt[d]    <= 0;
        macc[d]  <= -1000;
        mcode[d] <= 3'd0;
        mnull[d] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        // Ready during the window after edge mt means a code is taken on edge mt+1.
        if (vin[d] && (mt[d] >= macc[d] + plen(d) + glen(d))) begin
          if (fin[d]) begin
            macc[d]  <= mt[d] + 1;
            mcode[d] <= cin[d];
          end else if (mnull[d] < 255) begin
            mnull[d] <= mnull[d] + 1;
          end
        end
        mt[d] <= mt[d] + 1;
      end
    end
  end

  // Expected {onehot, busy, in_ready, pulse_done, null_cnt} in the current window.
  function automatic logic [18:0] model_vec(int d);
    int         t;
    logic [7:0] oh;
    logic       bsy;
    logic       pd;
    t   = mt[d];
    oh  = ((t >= macc[d]) && (t <= macc[d] + plen(d) - 1)) ? (8'd1 << mcode[d]) : 8'd0;
    bsy = (t < macc[d] + plen(d) + glen(d));
    pd  = (t == macc[d] + plen(d));
    return {oh, bsy, ~bsy, pd, 8'(mnull[d])};
  endfunction

  function automatic logic [18:0] act_vec(int d);
    if (d == 0) return {a_onehot, a_busy, a_if.in_ready, a_pd, a_null};
    return {b_onehot, b_busy, b_if.in_ready, b_pd, b_null};
  endfunction

  function automatic logic rdy(int d);
    return (d == 0) ? a_if.in_ready : b_if.in_ready;
  endfunction

  function automatic logic bsy(int d);
    return (d == 0) ? a_busy : b_busy;
  endfunction

  task automatic check_vec(string name, logic [18:0] act, logic [18:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got {oh,busy,rdy,pd,null}=%h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(string name, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // One clock cycle; both DUTs are compared against the model every cycle.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check_vec("model_a", act_vec(0), model_vec(0));
    check_vec("model_b", act_vec(1), model_vec(1));
  endtask

  task automatic drive(int d, logic v, logic [2:0] c, logic f);
    if (d == 0) begin
      a_if.in_valid = v; a_if.in_code = c; a_if.in_f = f;
    end else begin
      b_if.in_valid = v; b_if.in_code = c; b_if.in_f = f;
    end
  endtask

  // Present a code, wait for ready, take the accept edge; returns in the window after that edge.
  task automatic send(int d, logic [2:0] c, logic f, output int acc);
    int budget;
    budget = 50;
    drive(d, 1'b1, c, f);
    while (!rdy(d) && budget > 0) begin
      step();
      budget--;
    end
    check_int("send_ready", int'(rdy(d)), 1);
    step();
    acc = cyc;
    drive(d, 1'b0, c, f);
  endtask

  task automatic wait_idle(int d);
    int budget;
    budget = 50;
    while (bsy(d) && budget > 0) begin
      step();
      budget--;
    end
    check_int("wait_idle", int'(bsy(d)), 0);
  endtask

  typedef struct {
    logic [2:0] code;
    logic       f;
    logic [7:0] exp_oh;
    int         exp_len;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, got no summary expected one");
    $fatal(1, "timeout");
  end

  initial begin
    int k, k2, n, g, nacc, last, budget, bad;
    logic will;

    tbl[0] = '{3'd0, 1'b1, 8'b0000_0001, PA};
    tbl[1] = '{3'd1, 1'b1, 8'b0000_0010, PA};
    tbl[2] = '{3'd2, 1'b1, 8'b0000_0100, PA};
    tbl[3] = '{3'd3, 1'b1, 8'b0000_1000, PA};
    tbl[4] = '{3'd4, 1'b1, 8'b0001_0000, PA};
    tbl[5] = '{3'd5, 1'b1, 8'b0010_0000, PA};
    tbl[6] = '{3'd6, 1'b1, 8'b0100_0000, PA};
    tbl[7] = '{3'd7, 1'b1, 8'b1000_0000, PA};
    tbl[8] = '{3'd3, 1'b0, 8'b0000_0000, 0};
    tbl[9] = '{3'd6, 1'b0, 8'b0000_0000, 0};

    drive(0, 1'b0, 3'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state: idle, ready, quiet, counters cleared.
    check_vec("reset_a", act_vec(0), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    check_vec("reset_b", act_vec(1), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00});

    // Code 5: four-cycle strobe, pulse_done on the first zero cycle, ready after one gap cycle.
    send(0, 3'd5, 1'b1, k);
    check_int("c5_onehot", a_onehot, 8'b0010_0000);
    n = 0; g = 0;
    while (a_onehot != 8'h00 && g < 20) begin n++; g++; step(); end
    check_int("c5_len", n, 4);
    check_int("c5_pulse_done", a_pd, 1);
    check_int("c5_ready_in_gap", a_if.in_ready, 0);
    step();
    check_int("c5_ready_after_gap", a_if.in_ready, 1);

    // Table: each code individually, plus null codes.
    for (int i = 0; i < 10; i++) begin
      send(0, tbl[i].code, tbl[i].f, k);
      check_int($sformatf("tbl%0d_onehot", i), a_onehot, tbl[i].exp_oh);
      n = 0; g = 0;
      while (a_onehot != 8'h00 && g < 20) begin n++; g++; step(); end
      check_int($sformatf("tbl%0d_len", i), n, tbl[i].exp_len);
      wait_idle(0);
    end

    // All eight codes with in_valid held high throughout.
    drive(0, 1'b1, 3'd0, 1'b1);
    nacc = 0; last = 0; budget = 200;
    while (nacc < 8 && budget > 0) begin
      will = a_if.in_ready;
      step();
      budget--;
      if (will) begin
        check_int($sformatf("held%0d_onehot", nacc), a_onehot, tbl[nacc].exp_oh);
        if (nacc > 0) check_int("held_spacing", cyc - last, PA + GA + 1);
        last = cyc;
        nacc++;
        a_if.in_code = 3'(nacc);
      end
    end
    drive(0, 1'b0, 3'd0, 1'b0);
    check_int("held_count", nacc, 8);
    wait_idle(0);

    // Code changes mid-pulse are ignored until the block is ready again.
    send(0, 3'd2, 1'b1, k);
    drive(0, 1'b1, 3'd7, 1'b1);
    for (int i = 0; i < PA; i++) begin
      check_int("hold2_onehot", a_onehot, 8'b0000_0100);
      step();
    end
    send(0, 3'd7, 1'b1, k2);
    check_int("late7_onehot", a_onehot, 8'b1000_0000);
    check_int("late7_spacing", k2 - k, PA + GA + 1);
    wait_idle(0);

    // 300 back-to-back null codes: never busy, saturating counter.
    drive(0, 1'b1, 3'd4, 1'b0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (a_busy || !a_if.in_ready || a_onehot != 8'h00) bad++;
    end
    drive(0, 1'b0, 3'd0, 1'b0);
    check_int("null_quiet_cycles", bad, 0);
    check_int("null_saturated", a_null, 255);
    step();
    check_int("null_stays_255", a_null, 255);

    // DUT B (PULSE_LEN=1, GAP_LEN=0): one-cycle strobe, pulse_done coincides with IDLE.
    send(1, 3'd6, 1'b1, k);
    check_int("b_onehot", b_onehot, 8'b0100_0000);
    check_int("b_busy_during", b_busy, 1);
    step();
    check_int("b_onehot_off", b_onehot, 0);
    check_int("b_pd", b_pd, 1);
    check_int("b_ready_with_pd", b_if.in_ready, 1);
    drive(1, 1'b1, 3'd1, 1'b1);
    nacc = 0; last = 0; budget = 50;
    while (nacc < 4 && budget > 0) begin
      will = b_if.in_ready;
      step();
      budget--;
      if (will) begin
        if (nacc > 0) check_int("b_spacing", cyc - last, PB + GB + 1);
        last = cyc;
        nacc++;
      end
    end
    drive(1, 1'b0, 3'd0, 1'b0);
    check_int("b_count", nacc, 4);
    wait_idle(1);

    // Random traffic on both builds against the model.
    for (int i = 0; i < 600; i++) begin
      drive(0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      drive(1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
      step();
    end
    drive(0, 1'b0, 3'd0, 1'b0);
    drive(1, 1'b0, 3'd0, 1'b0);
    wait_idle(0);
    wait_idle(1);

    // Asynchronous reset on cycle 2 of a pulse clears outputs before the next edge.
    send(0, 3'd3, 1'b1, k);
    step();
    check_int("pre_rst_onehot", a_onehot, 8'b0000_1000);
    #2;
    rst = 1'b1;
    #1;
    check_vec("async_rst_a", act_vec(0), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    check_vec("async_rst_b", act_vec(1), {8'h00, 1'b0, 1'b1, 1'b0, 8'h00});
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    send(0, 3'd0, 1'b1, k);
    check_int("post_rst_onehot", a_onehot, 8'b0000_0001);
    wait_idle(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/priority_decoder_pulser.md
Name: priority_decoder_pulser

Overview:
- Reverse direction of the team's 8:3 priority encoder.
- Accepts the encoder's output pair (3-bit index code plus valid flag f) through a valid/ready handshake.
- Decodes the index back to a one-hot 8-bit line and drives that line high for a programmable number of cycles, followed by a programmable guard gap.
- Used wherever an encoded request must become a timed one-hot strobe, e.g. interrupt acknowledge or channel select.

Parameters:
- IDX_W, 3: index width; one-hot output width is N = 2**IDX_W.
- PULSE_LEN, 4: cycles the decoded line is held high. Legal range is 1..255.
- GAP_LEN, 1: cycles of forced all-zero output after each pulse. Legal range is 0..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  code present on in_code/in_f.
- in_ready  output  1  block can accept a code this cycle.
- in_code  input  IDX_W  encoded index (encoder y).
- in_f  input  1  encoder "any input active" flag (encoder f).
- onehot  output  N  registered decoded strobe.
- busy  output  1  state is not IDLE.
- pulse_done  output  1  one-cycle flag on the first cycle after a pulse ends.
- null_cnt  output  8  saturating count of accepted codes with in_f=0.

Behaviour:
- Reset (async, immediate, any state):
  - onehot=0, pulse_done=0, null_cnt=0.
  - State forced to IDLE, internal counter=0.
  - Therefore in_ready=1 and busy=0.
  - Reset mid-pulse clears onehot without waiting for a clock edge.
- Handshake:
  - in_ready = (state==IDLE), decoded from state only; no combinational path from in_valid.
  - Accept occurs on a rising edge where in_valid && in_ready.
  - in_code and in_f are sampled only at accept; input changes at any other time are ignored.
  - in_valid may stay high while in_ready=0; the code is then accepted on the first IDLE cycle.
- State machine IDLE / PULSE / GAP:
  - IDLE, accept with in_f=1:
    - onehot <= 1 << in_code; state <= PULSE; cnt <= PULSE_LEN-1.
  - IDLE, accept with in_f=0:
    - onehot stays 0; null_cnt <= min(null_cnt+1, 255); state stays IDLE.
    - in_ready stays 1, so back-to-back null codes are accepted every cycle.
  - IDLE, no accept: outputs hold.
  - PULSE, cnt != 0: onehot holds; cnt decrements.
  - PULSE, cnt == 0:
    - onehot <= 0; pulse_done <= 1.
    - If GAP_LEN > 0: state <= GAP, cnt <= GAP_LEN-1. Otherwise state <= IDLE.
  - GAP: onehot = 0. If cnt == 0, state <= IDLE; otherwise cnt decrements.
  - pulse_done is high for exactly one cycle and is 0 in every other cycle.
- Timing:
  - For an accept at edge k, onehot is high from edge k+1 through edge k+PULSE_LEN, i.e. exactly PULSE_LEN cycles.
  - onehot is zero for GAP_LEN cycles after the pulse, plus at least 1 IDLE cycle.
  - Minimum spacing between valid accepts is PULSE_LEN+GAP_LEN+1 cycles.
- Output invariants:
  - onehot is always either zero or exactly one bit set.
  - onehot is never nonzero outside PULSE.
- Widths and counters:
  - Internal counter width is 8 bits.
  - null_cnt saturates at 255 and never wraps.
- Out-of-range parameters:
  - PULSE_LEN=0 or a value >255 is an elaboration error; the design must stop elaboration with a fatal message.

Test Plan:
- Reset, then send in_code=5, in_f=1 for one cycle:
  - onehot=8'b0010_0000 for exactly 4 cycles, then 0.
  - pulse_done is high on the first zero cycle.
  - in_ready returns to 1 after 1 gap cycle.
- All 8 codes sent with in_valid held high continuously:
  - Each code produces the correct one-hot line.
  - Accept spacing is exactly 6 cycles.
  - No two bits of onehot are ever set together.
- in_code changed from 2 to 7 during a PULSE for code 2:
  - onehot stays 8'b0000_0100 for the full pulse.
  - 7 is accepted only when in_ready=1.
- 300 consecutive in_f=0 codes:
  - onehot stays 0 and busy stays 0.
  - in_ready stays 1.
  - null_cnt reads 255 at the end (saturated).
- rst asserted asynchronously mid-pulse (cycle 2 of 4):
  - onehot=0, busy=0, in_ready=1 before the next clock edge.
  - null_cnt=0.
- Build with GAP_LEN=0, PULSE_LEN=1:
  - Every accept gives a 1-cycle pulse.
  - Accept spacing is 2 cycles.
  - pulse_done coincides with the IDLE cycle.
